// File: rtl/seg7_pattern_reader.sv
// Recovers the hex digit shown on a 7-segment bus (a..g, active-high lit).
// Synchronises, debounces and decodes the segments, then offers each new digit on valid/ready.
//
// state  | meaning
// IDLE   | synchronised pattern equals the candidate; waiting for a change
// SETTLE | candidate loaded; counting stable cycles before the commit check
module seg7_pattern_reader #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       blank,
    output logic       err,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic       led
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_SETTLE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [0:0]       state;
    logic [6:0]       s1;
    logic [6:0]       s2;
    logic [6:0]       candidate;
    logic [6:0]       last_reported;
    logic [CNT_W-1:0] counter;

    logic [3:0] dec_value;
    logic       dec_blank;
    logic       dec_err;
    logic       settle_done;
    logic       commit;
    logic       transfer;

    always_comb begin
        dec_value = 4'h0;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (candidate)
            7'h7E: dec_value = 4'h0;
            7'h30: dec_value = 4'h1;
            7'h6D: dec_value = 4'h2;
            7'h79: dec_value = 4'h3;
            7'h33: dec_value = 4'h4;
            7'h5B: dec_value = 4'h5;
            7'h5F: dec_value = 4'h6;
            7'h70: dec_value = 4'h7;
            7'h7F: dec_value = 4'h8;
            7'h7B: dec_value = 4'h9;
            7'h77: dec_value = 4'hA;
            7'h1F: dec_value = 4'hB;
            7'h4E: dec_value = 4'hC;
            7'h3D: dec_value = 4'hD;
            7'h4F: dec_value = 4'hE;
            7'h47: dec_value = 4'hF;
            7'h00: dec_blank = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    assign settle_done = (state == ST_SETTLE) && (s2 == candidate) && (counter == CNT_LAST);
    // Returning to the last reported pattern after a glitch must not produce a duplicate word.
    assign commit      = settle_done && (candidate != last_reported);
    assign transfer    = out_valid && out_ready;
    assign led         = err && out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 7'h00;
            s2 <= 7'h00;
        end else begin
            s1 <= seg;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            candidate     <= 7'h00;
            counter       <= '0;
            last_reported <= 7'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s2 != candidate) begin
                        candidate <= s2;
                        counter   <= '0;
                        state     <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (s2 != candidate) begin
                        candidate <= s2;
                        counter   <= '0;
                    end else if (counter == CNT_LAST) begin
                        state <= ST_IDLE;
                        if (commit) last_reported <= candidate;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= 4'h0;
            blank     <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (commit) begin
            value     <= dec_value;
            blank     <= dec_blank;
            err       <= dec_err;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_pattern_reader.sv
// Bench for seg7_pattern_reader: directed scenarios plus random segment traffic,
// checked every cycle against a run-length model of the debounced segment stream.
module tb_seg7_pattern_reader;

    localparam int STABLE = 4;
    localparam logic [6:0] PAT [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg = 7'h00;
    logic       out_ready = 1'b0;
    logic [3:0] value;
    logic       blank, err, out_valid, overrun, led;

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    logic [6:0] h1, h2, prev_obs, last_rep;
    int         run_len;
    logic [3:0] m_value;
    logic       m_blank, m_err, m_valid, m_overrun;

    seg7_pattern_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .value(value), .blank(blank), .err(err),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        h1 = 7'h00; h2 = 7'h00; prev_obs = 7'h00; last_rep = 7'h00; run_len = 0;
        m_value = 4'h0; m_blank = 1'b0; m_err = 1'b0; m_valid = 1'b0; m_overrun = 1'b0;
    endtask

    // The FSM sees the segment value sampled two edges earlier; a word commits once a new
    // value has been seen on STABLE+1 consecutive edges and differs from the last one reported.
    task automatic model_edge();
        logic [6:0] obs;
        logic       fire;
        obs = h2;
        h2  = h1;
        h1  = seg;
        fire = 1'b0;
        if (obs != prev_obs) begin
            prev_obs = obs;
            run_len  = 1;
        end else if (run_len > 0) begin
            run_len++;
        end
        if (run_len == STABLE + 1 && obs != last_rep) fire = 1'b1;
        if (fire) begin
            last_rep = obs;
            if (m_valid && !out_ready) m_overrun = 1'b1;
            m_valid = 1'b1;
            m_value = 4'h0; m_blank = 1'b0; m_err = 1'b1;
            if (obs == 7'h00) begin
                m_err = 1'b0; m_blank = 1'b1;
            end
            for (int i = 0; i < 16; i++) begin
                if (PAT[i] == obs) begin
                    m_value = 4'(i); m_err = 1'b0;
                end
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},   {7'h0, out_valid}, {7'h0, m_valid});
        chk({tag, ".overrun"}, {7'h0, overrun},   {7'h0, m_overrun});
        chk({tag, ".led"},     {7'h0, led},       {7'h0, m_err & m_valid});
        if (m_valid) begin
            chk({tag, ".value"}, {4'h0, value}, {4'h0, m_value});
            chk({tag, ".blank"}, {7'h0, blank}, {7'h0, m_blank});
            chk({tag, ".err"},   {7'h0, err},   {7'h0, m_err});
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic hold(input logic [6:0] p, input int n, input string tag);
        seg = p;
        for (int k = 0; k < n; k++) tick(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".value"},   {4'h0, value}, 8'h00);
        chk({tag, ".blank"},   {7'h0, blank}, 8'h00);
        chk({tag, ".err"},     {7'h0, err}, 8'h00);
        chk({tag, ".valid"},   {7'h0, out_valid}, 8'h00);
        chk({tag, ".overrun"}, {7'h0, overrun}, 8'h00);
        chk({tag, ".led"},     {7'h0, led}, 8'h00);
    endtask

    initial begin
        model_reset();
        #12;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Blank equals last_reported after reset: no word
        hold(7'h00, 20, "idle_blank");
        chk("idle_blank.no_word", {7'h0, out_valid}, 8'h00);

        // Latency of the first word
        hold(7'h6D, 6, "lat");
        chk("lat.before_edge6", {7'h0, out_valid}, 8'h00);
        tick("lat");
        chk("lat.valid_edge6", {7'h0, out_valid}, 8'h01);
        chk("lat.value2", {4'h0, value}, 8'h02);
        out_ready = 1'b1;
        tick("lat_accept");
        out_ready = 1'b0;
        chk("lat.dropped", {7'h0, out_valid}, 8'h00);

        // All 16 patterns in order with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) hold(PAT[i], 10, "walk");
        chk("walk.no_overrun", {7'h0, overrun}, 8'h00);

        // Short glitch and return to the last reported pattern
        hold(7'h30, 10, "glitch_pre");
        hold(7'h7F, 3, "glitch");
        hold(7'h30, 12, "glitch_post");
        chk("glitch.no_word", {7'h0, out_valid}, 8'h00);
        out_ready = 1'b0;

        // Unknown pattern and blank
        hold(7'h01, 10, "bad");
        chk("bad.err", {7'h0, err}, 8'h01);
        chk("bad.led", {7'h0, led}, 8'h01);
        chk("bad.value", {4'h0, value}, 8'h00);
        hold(7'h00, 10, "blank");
        chk("blank.blank", {7'h0, blank}, 8'h01);
        chk("blank.led", {7'h0, led}, 8'h00);

        // Overrun while the consumer stalls
        hold(7'h79, 10, "ovr");
        hold(7'h33, 10, "ovr");
        chk("ovr.overrun", {7'h0, overrun}, 8'h01);
        chk("ovr.value4", {4'h0, value}, 8'h04);
        out_ready = 1'b1;
        tick("ovr_accept");
        out_ready = 1'b0;
        hold(7'h33, 5, "ovr_sticky");
        chk("ovr.sticky", {7'h0, overrun}, 8'h01);

        // Reset in the middle of settling
        hold(7'h5B, 5, "mid_rst");
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        model_reset();
        #2;
        rst_n = 1'b1;
        hold(7'h5B, 6, "post_rst");
        chk("post_rst.before_edge6", {7'h0, out_valid}, 8'h00);
        tick("post_rst");
        chk("post_rst.valid", {7'h0, out_valid}, 8'h01);
        chk("post_rst.value5", {4'h0, value}, 8'h05);

        // Random traffic against the model
        for (int it = 0; it < 80; it++) begin
            int kind;
            int len;
            logic [6:0] p;
            kind = int'($urandom_range(0, 9));
            if (kind < 7)       p = PAT[$urandom_range(0, 15)];
            else if (kind == 7) p = 7'h00;
            else                p = 7'($urandom);
            len = int'($urandom_range(1, 9));
            seg = p;
            for (int k = 0; k < len; k++) begin
                out_ready = ($urandom_range(0, 2) == 0);
                tick("rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_pattern_reader.md
Name: seg7_pattern_reader

Overview:
- Reads a 7-segment display bus (segments a..g, active-high lit) and recovers the displayed hex digit as a 4-bit value.
- Synchronises the segment lines, debounces them with a stability counter, decodes each newly stable pattern, and presents it on a valid/ready output with overrun detection.
- Sits on the display-monitor side, as the inverse of the team's value-to-segment decoders; used for self-check and loopback of display paths.

Parameters:
- STABLE_CYCLES, 4, synchronised cycles a pattern must stay unchanged before commit; legal range 2..255.
- CNT_W, 8, stability counter width; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- seg  input  7  raw segment lines; seg[6]=a ... seg[0]=g; 1 = lit.
- value  output  4  decoded hex digit of the held word.
- blank  output  1  held word was all segments off.
- err  output  1  held word was a pattern not in the hex table.
- out_valid  output  1  held word available.
- out_ready  input  1  consumer accepts the held word.
- overrun  output  1  sticky: an unaccepted word was overwritten.
- led  output  1  equals err AND out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - value=0, blank=0, err=0, out_valid=0, overrun=0, led=0.
  - Sync flops = 0, candidate = 0, counter = 0, last_reported = 7'h00.
  - State = IDLE.
  - Assertion mid-settle or mid-hold discards everything; no partial commit after release.
- Synchroniser: two flops (s1, s2). Decode logic sees only s2.
- States:
  - IDLE: s2 == candidate. If s2 != candidate: candidate <= s2, counter <= 0, go to SETTLE.
  - SETTLE: if s2 != candidate, reload candidate, counter <= 0, stay in SETTLE. Else if counter == STABLE_CYCLES-1, go to COMMIT check. Else counter++.
  - COMMIT check, same edge: if candidate != last_reported, load the output word and set last_reported <= candidate; otherwise no output. Return to IDLE either way.
- Latency: edge 0 is the first edge sampling the new stable seg. s2 updates at edge 1, candidate loads at edge 2, commit occurs at edge STABLE_CYCLES+2. out_valid is high after edge 6 for the default.
- Decode table (seg hex -> value), all with err=0, blank=0:
  - 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7.
  - 7F->8, 7B->9, 77->A, 1F->b, 4E->C, 3D->d, 4F->E, 47->F.
- 00 -> value=0, blank=1, err=0.
- Any other pattern -> value=0, blank=0, err=1.
- Handshake:
  - A word transfers on an edge with out_valid=1 and out_ready=1; out_valid then drops unless a commit happens on the same edge.
  - Commit while out_valid=1 and out_ready=0: word overwritten with the newest, out_valid stays 1, overrun <= 1.
  - Commit on the same edge as a transfer: new word loaded, out_valid stays 1, no overrun.
  - overrun clears only on reset.
  - out_ready while out_valid=0 is ignored.
- A glitch shorter than STABLE_CYCLES synchronised cycles never commits. A return to the last reported pattern after a glitch does not re-commit.

Test Plan:
- Reset, seg=7'h00 held 20 cycles -> out_valid stays 0 (equals last_reported). Then seg=7'h6D held -> out_valid=1 after edge 6 with value=2, err=0, blank=0. out_ready=1 for one cycle -> out_valid=0.
- Step seg through all 16 table patterns, each held 10 cycles, out_ready=1 -> 16 words in order with values 0..F and no overrun.
- seg=7'h30 stable and accepted; pulse seg=7'h7F for 3 cycles, then back to 7'h30 -> no new word, out_valid stays 0.
- seg=7'h01 held 10 cycles -> err=1, led=1, value=0. Then seg=7'h00 -> blank=1, led=0.
- out_ready=0; seg 7'h79 then 7'h33, each held 10 cycles -> overrun=1, value=4. Assert out_ready -> transfer; overrun stays 1 until rst_n pulse.
- Pull rst_n low at SETTLE counter=2 while seg=7'h5B -> all outputs 0 immediately. After release with seg still 7'h5B -> word value=5 at edge 6 after release.
